// File: rtl/prim_ram_2p_scrub.sv
// Single-clock true dual-port RAM with a sequencer that clears every word.
// Same-address writes resolve per mask group, and each port returns read-valid and out-of-range strobes.
module prim_ram_2p_scrub #(
   parameter int unsigned      Width           = 32,
   parameter int unsigned      Depth           = 128,
   parameter int unsigned      DataBitsPerMask = 8,
   parameter int unsigned      OutputReg       = 0,
   parameter int unsigned      WriteFirst      = 0,
   parameter logic [Width-1:0] ClearValue      = '0,
   localparam int unsigned     Aw              = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             a_req_i,
   input  logic             a_write_i,
   input  logic [Aw-1:0]    a_addr_i,
   input  logic [Width-1:0] a_wdata_i,
   input  logic [Width-1:0] a_wmask_i,
   output logic [Width-1:0] a_rdata_o,
   output logic             a_rvalid_o,
   output logic             a_oob_o,
   input  logic             b_req_i,
   input  logic             b_write_i,
   input  logic [Aw-1:0]    b_addr_i,
   input  logic [Width-1:0] b_wdata_i,
   input  logic [Width-1:0] b_wmask_i,
   output logic [Width-1:0] b_rdata_o,
   output logic             b_rvalid_o,
   output logic             b_oob_o,
   input  logic             clr_req_i,
   output logic             clr_busy_o,
   output logic             clr_done_o,
   output logic             collision_o
);

   localparam int            Db        = DataBitsPerMask;
   localparam int            NumGroups = Width / DataBitsPerMask;
   localparam logic [Aw-1:0] LastAddr  = Aw'(Depth - 1);

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [Aw-1:0] clr_cnt_q, clr_cnt_d;
   logic          clr_done_q, clr_done_d;
   logic          collision_q, collision_d;
   logic          accept;

   logic [Width-1:0] mem_q [Depth];

   // Index 0 is port A, index 1 is port B.
   logic [1:0]                      req, write, inb, rd_acc, wr_acc;
   logic [1:0]                      rvalid_out, oob_out;
   logic [1:0][Aw-1:0]              addr;
   logic [1:0][Width-1:0]           wdata, wmask, rdata_out;
   logic [1:0][NumGroups-1:0]       grp_we, grp_full, grp_empty;

   assign req    = {b_req_i, a_req_i};
   assign write  = {b_write_i, a_write_i};
   assign addr   = {b_addr_i, a_addr_i};
   assign wdata  = {b_wdata_i, a_wdata_i};
   assign wmask  = {b_wmask_i, a_wmask_i};
   assign accept = (state_q == IDLE) && !clr_req_i && !rst_i;

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam int Other = 1 - gi;
      logic [Width-1:0] rd_word;
      logic             s1_valid_q, s1_oob_q;
      logic [Width-1:0] s1_data_q;

      if (Depth == (2 ** Aw)) begin : g_pow2
         assign inb[gi] = 1'b1;
      end else begin : g_npow2
         assign inb[gi] = (addr[gi] <= LastAddr);
      end

      assign rd_acc[gi] = accept && req[gi] && !write[gi];
      assign wr_acc[gi] = accept && req[gi] && write[gi];

      for (genvar gj = 0; gj < NumGroups; gj++) begin : g_grp
         assign grp_full[gi][gj]  = &wmask[gi][gj*Db +: Db];
         assign grp_empty[gi][gj] = ~|wmask[gi][gj*Db +: Db];
         assign grp_we[gi][gj]    = wr_acc[gi] && inb[gi] && grp_full[gi][gj];
      end

      // Write-first forwarding merges the other port's enabled groups into the old word.
      always_comb begin
         rd_word = '0;
         if (inb[gi]) begin
            rd_word = mem_q[addr[gi]];
            if (WriteFirst != 0 && addr[Other] == addr[gi]) begin
               for (int g = 0; g < NumGroups; g++) begin
                  if (grp_we[Other][g]) begin
                     rd_word[g*Db +: Db] = wdata[Other][g*Db +: Db];
                  end
               end
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_oob_q   <= 1'b0;
            s1_data_q  <= '0;
         end else begin
            s1_valid_q <= rd_acc[gi];
            s1_oob_q   <= (rd_acc[gi] || wr_acc[gi]) && !inb[gi];
            if (rd_acc[gi]) begin
               s1_data_q <= rd_word;
            end
         end
      end

      if (OutputReg != 0) begin : g_oreg
         logic             s2_valid_q, s2_oob_q;
         logic [Width-1:0] s2_data_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               s2_valid_q <= 1'b0;
               s2_oob_q   <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s1_valid_q;
               s2_oob_q   <= s1_oob_q;
               if (s1_valid_q) begin
                  s2_data_q <= s1_data_q;
               end
            end
         end

         assign rvalid_out[gi] = s2_valid_q;
         assign oob_out[gi]    = s2_oob_q;
         assign rdata_out[gi]  = s2_data_q;
      end else begin : g_noreg
         assign rvalid_out[gi] = s1_valid_q;
         assign oob_out[gi]    = s1_oob_q;
         assign rdata_out[gi]  = s1_data_q;
      end

      assert property (@(posedge clk_i) disable iff (rst_i)
         wr_acc[gi] |-> &(grp_full[gi] | grp_empty[gi]));
   end

   // Port A is written last so it overrides port B on groups both enable.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= ClearValue;
         end else begin
            for (int g = 0; g < NumGroups; g++) begin
               if (grp_we[1][g]) begin
                  mem_q[addr[1]][g*Db +: Db] <= wdata[1][g*Db +: Db];
               end
               if (grp_we[0][g]) begin
                  mem_q[addr[0]][g*Db +: Db] <= wdata[0][g*Db +: Db];
               end
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      clr_done_d  = 1'b0;
      collision_d = wr_acc[0] && wr_acc[1] && inb[0] && inb[1] && (addr[0] == addr[1]);
      case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LastAddr) begin
               state_d    = IDLE;
               clr_cnt_d  = '0;
               clr_done_d = 1'b1;
            end
         end
         IDLE: begin
            if (clr_req_i) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         clr_done_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         clr_done_q  <= clr_done_d;
         collision_q <= collision_d;
      end
   end

   assign a_rdata_o   = rdata_out[0];
   assign a_rvalid_o  = rvalid_out[0];
   assign a_oob_o     = oob_out[0];
   assign b_rdata_o   = rdata_out[1];
   assign b_rvalid_o  = rvalid_out[1];
   assign b_oob_o     = oob_out[1];
   assign clr_busy_o  = (state_q == CLEAR);
   assign clr_done_o  = clr_done_q;
   assign collision_o = collision_q;

endmodule

// File: tb/tb_prim_ram_2p_scrub.sv
// Bench for prim_ram_2p_scrub: two configurations driven by the same stimulus,
// each checked every cycle against a word-level reference model.
module tb_prim_ram_2p_scrub;

   localparam int          AW  = 7;
   localparam logic [31:0] CV0 = 32'hCAFE_0001;
   localparam logic [31:0] CV1 = 32'h5EED_F00D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, clr_req;
   logic          a_req, a_write, b_req, b_write;
   logic [AW-1:0] a_addr, b_addr;
   logic [31:0]   a_wdata, b_wdata, a_wmask, b_wmask;

   logic [31:0] d0_a_rdata, d0_b_rdata, d1_a_rdata, d1_b_rdata;
   logic        d0_a_rvalid, d0_b_rvalid, d1_a_rvalid, d1_b_rvalid;
   logic        d0_a_oob, d0_b_oob, d1_a_oob, d1_b_oob;
   logic        d0_busy, d0_done, d0_coll, d1_busy, d1_done, d1_coll;

   prim_ram_2p_scrub #(.Width(32), .Depth(128), .DataBitsPerMask(8), .OutputReg(0),
                       .WriteFirst(0), .ClearValue(CV0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_wmask_i(a_wmask), .a_rdata_o(d0_a_rdata), .a_rvalid_o(d0_a_rvalid), .a_oob_o(d0_a_oob),
      .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_wmask_i(b_wmask), .b_rdata_o(d0_b_rdata), .b_rvalid_o(d0_b_rvalid), .b_oob_o(d0_b_oob),
      .clr_req_i(clr_req), .clr_busy_o(d0_busy), .clr_done_o(d0_done), .collision_o(d0_coll));

   prim_ram_2p_scrub #(.Width(32), .Depth(100), .DataBitsPerMask(8), .OutputReg(1),
                       .WriteFirst(1), .ClearValue(CV1)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_wmask_i(a_wmask), .a_rdata_o(d1_a_rdata), .a_rvalid_o(d1_a_rvalid), .a_oob_o(d1_a_oob),
      .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_wmask_i(b_wmask), .b_rdata_o(d1_b_rdata), .b_rvalid_o(d1_b_rvalid), .b_oob_o(d1_b_oob),
      .clr_req_i(clr_req), .clr_busy_o(d1_busy), .clr_done_o(d1_done), .collision_o(d1_coll));

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: per instance depth, latency, write-first flag and clear word.
   int          depth_m [2] = '{128, 100};
   int          lat_m   [2] = '{1, 2};
   bit          wf_m    [2] = '{1'b0, 1'b1};
   logic [31:0] cv_m    [2] = '{CV0, CV1};
   logic [31:0] mmem    [2][128];
   int          clr_left [2];
   bit          exp_done [2];
   bit          exp_coll [2];
   logic [31:0] hold     [2][2];

   typedef struct {
      int          inst;
      int          port;
      int          due;
      bit          rv;
      bit          oob;
      logic [31:0] data;
   } rd_t;
   rd_t pq[$];

   logic [31:0] obs_rd  [2][2];
   logic        obs_rv  [2][2];
   logic        obs_oob [2][2];
   logic        obs_busy[2], obs_done[2], obs_coll[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic sample();
      obs_rd[0][0] = d0_a_rdata;  obs_rd[0][1] = d0_b_rdata;
      obs_rd[1][0] = d1_a_rdata;  obs_rd[1][1] = d1_b_rdata;
      obs_rv[0][0] = d0_a_rvalid; obs_rv[0][1] = d0_b_rvalid;
      obs_rv[1][0] = d1_a_rvalid; obs_rv[1][1] = d1_b_rvalid;
      obs_oob[0][0] = d0_a_oob;   obs_oob[0][1] = d0_b_oob;
      obs_oob[1][0] = d1_a_oob;   obs_oob[1][1] = d1_b_oob;
      obs_busy[0] = d0_busy; obs_done[0] = d0_done; obs_coll[0] = d0_coll;
      obs_busy[1] = d1_busy; obs_done[1] = d1_done; obs_coll[1] = d1_coll;
   endtask

   task automatic model_step();
      logic          rq [2];
      logic          wr [2];
      logic [AW-1:0] ad [2];
      logic [31:0]   wd [2];
      logic [31:0]   wm [2];
      bit            wok [2];
      bit            inb;
      logic [31:0]   rd;
      rd_t           e;
      rq[0] = a_req;   rq[1] = b_req;
      wr[0] = a_write; wr[1] = b_write;
      ad[0] = a_addr;  ad[1] = b_addr;
      wd[0] = a_wdata; wd[1] = b_wdata;
      wm[0] = a_wmask; wm[1] = b_wmask;
      for (int i = 0; i < 2; i++) begin
         exp_done[i] = 1'b0;
         exp_coll[i] = 1'b0;
         if (rst) begin
            clr_left[i] = depth_m[i];
            hold[i][0] = '0;
            hold[i][1] = '0;
            for (int k = pq.size() - 1; k >= 0; k--) if (pq[k].inst == i) pq.delete(k);
         end else if (clr_left[i] > 0) begin
            mmem[i][depth_m[i] - clr_left[i]] = cv_m[i];
            clr_left[i]--;
            exp_done[i] = (clr_left[i] == 0);
         end else if (clr_req) begin
            clr_left[i] = depth_m[i];
         end else begin
            for (int p = 0; p < 2; p++) wok[p] = rq[p] && wr[p] && (int'(ad[p]) < depth_m[i]);
            for (int p = 0; p < 2; p++) begin
               if (rq[p]) begin
                  inb = int'(ad[p]) < depth_m[i];
                  e.inst = i; e.port = p; e.due = cyc + lat_m[i];
                  if (!wr[p]) begin
                     rd = inb ? mmem[i][ad[p]] : 32'h0;
                     if (inb && wf_m[i] && wok[1-p] && ad[1-p] == ad[p])
                        rd = (rd & ~wm[1-p]) | (wd[1-p] & wm[1-p]);
                     e.rv = 1'b1; e.oob = !inb; e.data = rd;
                     pq.push_back(e);
                  end else if (!inb) begin
                     e.rv = 1'b0; e.oob = 1'b1; e.data = '0;
                     pq.push_back(e);
                  end
               end
            end
            for (int p = 1; p >= 0; p--)
               if (wok[p]) mmem[i][ad[p]] = (mmem[i][ad[p]] & ~wm[p]) | (wd[p] & wm[p]);
            exp_coll[i] = wok[0] && wok[1] && (ad[0] == ad[1]);
         end
      end
   endtask

   task automatic check_all();
      bit ev, eo;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            ev = 1'b0;
            eo = 1'b0;
            foreach (pq[k]) begin
               if (pq[k].inst == i && pq[k].port == p && pq[k].due == cyc) begin
                  ev |= pq[k].rv;
                  eo |= pq[k].oob;
                  if (pq[k].rv) hold[i][p] = pq[k].data;
               end
            end
            chk($sformatf("rvalid d%0d p%0d", i, p), obs_rv[i][p], ev);
            chk($sformatf("oob d%0d p%0d", i, p), obs_oob[i][p], eo);
            chk($sformatf("rdata d%0d p%0d", i, p), obs_rd[i][p], hold[i][p]);
         end
         chk($sformatf("busy d%0d", i), obs_busy[i], clr_left[i] > 0);
         chk($sformatf("done d%0d", i), obs_done[i], exp_done[i]);
         chk($sformatf("collision d%0d", i), obs_coll[i], exp_coll[i]);
      end
      for (int k = pq.size() - 1; k >= 0; k--) if (pq[k].due <= cyc) pq.delete(k);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      sample();
      check_all();
   endtask

   task automatic set_a(input logic r, input logic w, input logic [AW-1:0] ad,
                        input logic [31:0] wd, input logic [31:0] wm);
      a_req = r; a_write = w; a_addr = ad; a_wdata = wd; a_wmask = wm;
   endtask

   task automatic set_b(input logic r, input logic w, input logic [AW-1:0] ad,
                        input logic [31:0] wd, input logic [31:0] wm);
      b_req = r; b_write = w; b_addr = ad; b_wdata = wd; b_wmask = wm;
   endtask

   task automatic idle();
      set_a(1'b0, 1'b0, '0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0, '0);
      clr_req = 1'b0;
      rst     = 1'b0;
   endtask

   function automatic logic [31:0] rmask();
      logic [3:0]  s;
      logic [31:0] m;
      s = 4'($urandom);
      for (int g = 0; g < 4; g++) m[g*8 +: 8] = {8{s[g]}};
      return m;
   endfunction

   typedef struct {
      bit          do_wr;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] wmask;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_t;

   function automatic vec_t mkv(input bit w, input logic [6:0] ad, input logic [31:0] wd,
                                input logic [31:0] wm, input logic [31:0] e0, input logic [31:0] e1);
      vec_t v;
      v.do_wr = w; v.addr = ad; v.wdata = wd; v.wmask = wm; v.exp0 = e0; v.exp1 = e1;
      return v;
   endfunction

   initial begin
      vec_t        vt[$];
      int          nb0, nb1, nd0, nd1, at0, at1;
      logic [4:0]  v0, v1, o1;
      logic [6:0]  lat_addr [3];

      vt.push_back(mkv(0, 7'd0,   32'h0,         32'h0,         CV0,           CV1));
      vt.push_back(mkv(0, 7'd64,  32'h0,         32'h0,         CV0,           CV1));
      vt.push_back(mkv(0, 7'd127, 32'h0,         32'h0,         CV0,           32'h0));
      vt.push_back(mkv(0, 7'd99,  32'h0,         32'h0,         CV0,           CV1));
      vt.push_back(mkv(1, 7'd10,  32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678));
      vt.push_back(mkv(1, 7'd10,  32'hAABB_CCDD, 32'h00FF_00FF, 32'h12BB_56DD, 32'h12BB_56DD));
      vt.push_back(mkv(1, 7'd10,  32'hFFFF_FFFF, 32'h0000_0000, 32'h12BB_56DD, 32'h12BB_56DD));
      vt.push_back(mkv(1, 7'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0));
      vt.push_back(mkv(1, 7'd127, 32'h8765_4321, 32'hFFFF_FFFF, 32'h8765_4321, 32'h0));
      vt.push_back(mkv(1, 7'd99,  32'h0BAD_F00D, 32'hFF00_FF00, 32'h0BFE_F001, 32'h0BED_F00D));

      idle();
      rst = 1'b1;
      repeat (3) tick();
      chk("reset busy d0", d0_busy, 1);
      chk("reset busy d1", d1_busy, 1);
      chk("reset rvalid d1 a", d1_a_rvalid, 0);
      chk("reset rdata d0 b", d0_b_rdata, 0);

      // Clear after reset release: busy for Depth cycles, then one done pulse.
      rst = 1'b0;
      nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0; at0 = -1; at1 = -1;
      for (int k = 0; k < 140; k++) begin
         nb0 += int'(d0_busy); nb1 += int'(d1_busy);
         nd0 += int'(d0_done); nd1 += int'(d1_done);
         tick();
      end
      chk("clear busy cycles d0", nb0, 128);
      chk("clear busy cycles d1", nb1, 100);
      chk("clear done pulses d0", nd0, 1);
      chk("clear done pulses d1", nd1, 1);

      foreach (vt[k]) begin
         if (vt[k].do_wr) begin
            set_a(1'b1, 1'b1, vt[k].addr, vt[k].wdata, vt[k].wmask);
            tick();
         end
         set_a(1'b1, 1'b0, vt[k].addr, '0, '0);
         tick();
         idle();
         tick();
         tick();
         chk($sformatf("vec%0d rdata d0", k), d0_a_rdata, vt[k].exp0);
         chk($sformatf("vec%0d rdata d1", k), d1_a_rdata, vt[k].exp1);
         $display("vec %0d addr=%0d wr=%0d d0=%h d1=%h", k, vt[k].addr, vt[k].do_wr,
                  d0_a_rdata, d1_a_rdata);
      end

      // Same-address double write: A wins its groups, collision strobes once.
      set_a(1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      set_b(1'b1, 1'b1, 7'd5, 32'h1122_3344, 32'h0000_FFFF);
      tick();
      idle();
      chk("collision d0", d0_coll, 1);
      chk("collision d1", d1_coll, 1);
      tick();
      chk("collision one-shot d0", d0_coll, 0);
      set_a(1'b1, 1'b0, 7'd5, '0, '0);
      tick(); idle(); tick(); tick();
      chk("collision word d0", d0_a_rdata, 32'hDEAD_BEEF);
      chk("collision word d1", d1_a_rdata, 32'hDEAD_BEEF);

      // Opposite-port read during write: old word vs forwarded new word.
      set_a(1'b1, 1'b1, 7'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
      tick();
      set_a(1'b1, 1'b1, 7'd7, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
      set_b(1'b1, 1'b0, 7'd7, '0, '0);
      tick(); idle(); tick(); tick();
      chk("read-during-write d0 (old)", d0_b_rdata, 32'hA5A5_A5A5);
      chk("read-during-write d1 (new)", d1_b_rdata, 32'h5A5A_5A5A);

      // Back-to-back reads of 3, 99, 100 to see latency and the range strobe.
      lat_addr[0] = 7'd3; lat_addr[1] = 7'd99; lat_addr[2] = 7'd100;
      v0 = '0; v1 = '0; o1 = '0;
      for (int k = 0; k < 5; k++) begin
         if (k < 3) set_a(1'b1, 1'b0, lat_addr[k], '0, '0);
         else idle();
         tick();
         v0[k] = d0_a_rvalid; v1[k] = d1_a_rvalid; o1[k] = d1_a_oob;
      end
      chk("latency rvalid d0", v0, 5'b00111);
      chk("latency rvalid d1", v1, 5'b01110);
      chk("latency oob d1", o1, 5'b01000);
      chk("oob read data d1", d1_a_rdata, 32'h0);

      // Clear request drops same-cycle accesses; reset mid-clear restarts from zero.
      set_a(1'b1, 1'b0, 7'd20, '0, '0);
      set_b(1'b1, 1'b1, 7'd20, 32'h1234_5678, 32'hFFFF_FFFF);
      clr_req = 1'b1;
      tick();
      idle();
      chk("clr_req busy d0", d0_busy, 1);
      chk("clr_req dropped read d0", d0_a_rvalid, 0);
      repeat (39) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 300 && (at0 < 0 || at1 < 0); k++) begin
         tick();
         if (d0_done && at0 < 0) at0 = k;
         if (d1_done && at1 < 0) at1 = k;
      end
      chk("restart done delay d0", at0, 128);
      chk("restart done delay d1", at1, 100);
      set_b(1'b1, 1'b0, 7'd20, '0, '0);
      tick(); idle(); tick(); tick();
      chk("dropped write d0", d0_b_rdata, CV0);

      for (int k = 0; k < 3000; k++) begin
         rst     = ($urandom_range(0, 999) == 0);
         clr_req = ($urandom_range(0, 299) == 0);
         set_a($urandom_range(0, 3) != 0, 1'($urandom),
               ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127)),
               $urandom, rmask());
         set_b($urandom_range(0, 3) != 0, 1'($urandom),
               ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127)),
               $urandom, rmask());
         tick();
      end
      idle();
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
